// File: rtl/dp_gen_pkg.sv
// rtl/dp_gen_pkg.sv - default geometry and lane opcode / operand-source encodings for data_path_gen
package dp_gen_pkg;

   localparam int DEF_LANES    = 8;
   localparam int DEF_LANE_W   = 64;
   localparam int DEF_N_STAGES = 6;
   localparam int DEF_RF_DEPTH = 16;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MUL  = 2'b10,
      OP_PASS = 2'b11
   } lane_op_e;

   typedef enum logic [1:0] {
      SRC_UP  = 2'b00,
      SRC_ITR = 2'b01,
      SRC_IMM = 2'b10,
      SRC_RF  = 2'b11
   } opnd_src_e;

endpackage

// File: rtl/dp_stage.sv
// rtl/dp_stage.sv - one compute stage: operand muxes, SIMD lane ALUs, result register and local RF
module dp_stage
   import dp_gen_pkg::*;
#(
   parameter int LANES    = DEF_LANES,
   parameter int LANE_W   = DEF_LANE_W,
   parameter int RF_DEPTH = DEF_RF_DEPTH,
   localparam int PW      = LANES * LANE_W,
   localparam int AW      = $clog2(RF_DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          advance,
   input  logic          up_valid,
   input  logic [PW-1:0] up_data,
   input  logic [PW-1:0] itr,
   input  logic [PW-1:0] imm,
   input  logic [3:0]    sel,
   input  logic [1:0]    op,
   input  logic          wen_rf,
   input  logic [AW-1:0] rd_addr,
   input  logic [AW-1:0] wr_addr,
   output logic          stg_valid,
   output logic [PW-1:0] stg_data
);

   logic [PW-1:0]     rf_q [RF_DEPTH];
   logic [PW-1:0]     rf_d [RF_DEPTH];
   logic [PW-1:0]     data_q, data_d;
   logic              valid_q, valid_d;
   logic [PW-1:0]     rf_rdata, opnd_a, opnd_b, result;
   logic [LANE_W-1:0] lane_a, lane_b, lane_r;

   function automatic logic [PW-1:0] pick_opnd(input logic [1:0] src, input logic [PW-1:0] up,
                                                input logic [PW-1:0] it, input logic [PW-1:0] im,
                                                input logic [PW-1:0] rf);
      logic [PW-1:0] v;
      case (opnd_src_e'(src))
         SRC_ITR: v = it;
         SRC_IMM: v = im;
         SRC_RF:  v = rf;
         default: v = up;
      endcase
      return v;
   endfunction

   // Read is from the registered array, so a same-edge write is not visible until the next beat.
   assign rf_rdata = rf_q[rd_addr];
   assign opnd_a   = pick_opnd(sel[1:0], up_data, itr, imm, rf_rdata);
   assign opnd_b   = pick_opnd(sel[3:2], up_data, itr, imm, rf_rdata);

   always_comb begin
      result = '0;
      lane_a = '0;
      lane_b = '0;
      lane_r = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_a = opnd_a[l*LANE_W +: LANE_W];
         lane_b = opnd_b[l*LANE_W +: LANE_W];
         case (lane_op_e'(op))
            OP_ADD:  lane_r = lane_a + lane_b;
            OP_SUB:  lane_r = lane_a - lane_b;
            OP_MUL:  lane_r = lane_a * lane_b;
            OP_PASS: lane_r = lane_a;
         endcase
         result[l*LANE_W +: LANE_W] = lane_r;
      end
   end

   // Bubbles move the valid bit only; data and RF hold so the output phit stays stable.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      rf_d    = rf_q;
      if (advance) begin
         valid_d = up_valid;
         if (up_valid) begin
            data_d = result;
            if (wen_rf) begin
               rf_d[wr_addr] = result;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         for (int i = 0; i < RF_DEPTH; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         rf_q    <= rf_d;
      end
   end

   assign stg_valid = valid_q;
   assign stg_data  = data_q;

endmodule

// File: rtl/data_path_gen.sv
// rtl/data_path_gen.sv - N_STAGES deep SIMD compute pipeline with global stall on out_ready
module data_path_gen
   import dp_gen_pkg::*;
#(
   parameter int LANES    = DEF_LANES,
   parameter int LANE_W   = DEF_LANE_W,
   parameter int N_STAGES = DEF_N_STAGES,
   parameter int RF_DEPTH = DEF_RF_DEPTH,
   localparam int PW      = LANES * LANE_W,
   localparam int AW      = $clog2(RF_DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [PW-1:0]          in_data,
   input  logic [N_STAGES*PW-1:0] itr,
   input  logic [N_STAGES*PW-1:0] imm,
   input  logic [N_STAGES*4-1:0]  sel,
   input  logic [N_STAGES*2-1:0]  op,
   input  logic [N_STAGES-1:0]    wen_rf,
   input  logic [N_STAGES*AW-1:0] rd_addr,
   input  logic [N_STAGES*AW-1:0] wr_addr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PW-1:0]          out_data,
   output logic [4:0]             occupancy
);

   logic                advance;
   logic [N_STAGES-1:0] stg_valid;
   logic [PW-1:0]       stg_data [N_STAGES];

   assign out_valid = stg_valid[N_STAGES-1];
   assign out_data  = stg_data[N_STAGES-1];
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;

   for (genvar s = 0; s < N_STAGES; s++) begin : g_stage
      logic          up_valid;
      logic [PW-1:0] up_data;

      if (s == 0) begin : g_first
         assign up_valid = in_valid;
         assign up_data  = in_data;
      end else begin : g_rest
         assign up_valid = stg_valid[s-1];
         assign up_data  = stg_data[s-1];
      end

      dp_stage #(
         .LANES    (LANES),
         .LANE_W   (LANE_W),
         .RF_DEPTH (RF_DEPTH)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .advance   (advance),
         .up_valid  (up_valid),
         .up_data   (up_data),
         .itr       (itr[s*PW +: PW]),
         .imm       (imm[s*PW +: PW]),
         .sel       (sel[s*4 +: 4]),
         .op        (op[s*2 +: 2]),
         .wen_rf    (wen_rf[s]),
         .rd_addr   (rd_addr[s*AW +: AW]),
         .wr_addr   (wr_addr[s*AW +: AW]),
         .stg_valid (stg_valid[s]),
         .stg_data  (stg_data[s])
      );
   end

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < N_STAGES; i++) begin
         occupancy = occupancy + 5'(stg_valid[i]);
      end
   end

endmodule

// File: doc/data_path_gen.md
DATA_PATH_GEN -- requirements
Module: data_path_gen

Interface
REQ-001 Parameter LANES, default 8: number of SIMD lanes per phit.
REQ-002 Parameter LANE_W, default 64: bits per lane; phit width PW = LANES*LANE_W.
REQ-003 Parameter N_STAGES, default 6, legal range 1..16: number of compute stages.
REQ-004 Parameter RF_DEPTH, default 16, power of two >= 2: entries per stage register file; AW = log2(RF_DEPTH).
REQ-005 The clock port SHALL be clk; reset SHALL be rst_n, asynchronous, active-low; all logic SHALL use one clock.
REQ-006 Ports, as name / direction / width / meaning:
- clk / in / 1 / clock
- rst_n / in / 1 / async active-low reset
- in_valid / in / 1 / in_data valid
- in_ready / out / 1 / pipeline accepts in_data
- in_data / in / PW / inbound phit
- itr / in / N_STAGES*PW / per-stage iteration operand
- imm / in / N_STAGES*PW / per-stage immediate operand
- sel / in / N_STAGES*4 / per stage: [1:0] operand A source, [3:2] operand B source
- op / in / N_STAGES*2 / per-stage lane opcode
- wen_rf / in / N_STAGES / per-stage RF write enable
- rd_addr / in / N_STAGES*AW / per-stage RF read address
- wr_addr / in / N_STAGES*AW / per-stage RF write address
- out_valid / out / 1 / out_data valid
- out_ready / in / 1 / downstream accepts out_data
- out_data / out / PW / result phit of last stage
- occupancy / out / 5 / number of valid stages, 0..N_STAGES

Function
REQ-007 Each stage s SHALL select operands A and B per lane: 0 = upstream phit (in_data for s=0, stage s-1 register otherwise), 1 = itr slice s, 2 = imm slice s, 3 = RF s read data.
REQ-008 Lane opcode: 00 A+B, 01 A-B, 10 low LANE_W bits of A*B (unsigned), 11 pass A; add/sub wrap modulo 2^LANE_W; lanes independent.
REQ-009 Each stage SHALL register its result; latency from in accept to out_valid SHALL be exactly N_STAGES cycles with no stalls.
REQ-010 advance = !out_valid | out_ready; in_ready SHALL equal advance; all stage registers and valid bits SHALL update only when advance=1 (global stall).
REQ-011 On advance, stage 0 valid SHALL load in_valid; stage s valid SHALL load stage s-1 valid; out_valid SHALL be last-stage valid.
REQ-012 RF s read SHALL be combinational from rd_addr slice s; write of stage s new result to wr_addr slice s SHALL occur on clock edge when advance=1, upstream valid=1 and wen_rf[s]=1.
REQ-013 Read and write to same RF address in one cycle SHALL return the old contents.
REQ-014 Bubbles (invalid beats) SHALL never write RFs; stage data of invalid beats is don't-care but out_data SHALL hold its last value while out_valid=0.
REQ-015 occupancy SHALL equal the count of set stage valid bits, updated every cycle.
REQ-016 Control inputs (sel, op, addresses, itr, imm) SHALL be sampled at the edge where the beat enters that stage.

Reset
REQ-017 While rst_n=0: all stage valids, out_valid and occupancy SHALL be 0; stage registers, out_data and all RF entries SHALL be 0; in_ready SHALL be 1.
REQ-018 Reset asserted mid-stream SHALL discard all in-flight beats; no beat in flight at reset SHALL emerge after release.

Structure
REQ-019 Package dp_gen_pkg SHALL hold default LANES, LANE_W, N_STAGES, RF_DEPTH, the opcode enum and the operand-source enum.
REQ-020 One sub-module dp_stage (muxes, lane ALUs, result register, RF) SHALL be instantiated N_STAGES times via generate.

Verification (bench: LANES=2, LANE_W=16, N_STAGES=3, RF_DEPTH=4)
REQ-021 All stages sel=0x0/op=11, out_ready=1, one beat {lane1=5,lane0=7} -> out_valid high exactly 3 cycles later, out_data {5,7}, occupancy 1,1,1 then 0.
REQ-022 Stage 0 sel A=0,B=2, imm lanes=0xFFFF, op=00, input lanes=2 -> lane result 0x0001 (wrap).
REQ-023 Stage 1 op=10, B=itr lanes=0x0100, input lanes=0x0300 -> result 0x0000 (low bits of mult).
REQ-024 Streaming 10 back-to-back beats with out_ready low for 4 cycles mid-stream -> in_ready low those cycles, no beat lost or duplicated, order preserved, occupancy saturates at 3.
REQ-025 Stage 2 wen_rf=1 wr_addr=1 writes 0x0042; next beat sel A=3 rd_addr=1 -> 0x0042; same-cycle read/write of addr 1 returns prior value.
REQ-026 Assert rst_n low with 3 beats in flight -> out_valid=0, occupancy=0, RF reads 0 after release, none of the 3 beats appears.
